// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter for one pipelined SRAM-style slave port: the fetch stage (read-only)
// and the memory stage (read/write) share the slave, and in-order responses are routed back by owner ID.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               inst_req,
  input  logic [31:0]                        inst_addr,
  output logic                               inst_addr_ok,
  output logic                               inst_data_ok,
  output logic [31:0]                        inst_rdata,
  input  logic                               data_req,
  input  logic                               data_wr,
  input  logic [1:0]                         data_size,
  input  logic [31:0]                        data_addr,
  input  logic [31:0]                        data_wdata,
  output logic                               data_addr_ok,
  output logic                               data_data_ok,
  output logic [31:0]                        data_rdata,
  output logic                               mem_req,
  output logic                               mem_wr,
  output logic [1:0]                         mem_size,
  output logic [31:0]                        mem_addr,
  output logic [31:0]                        mem_wdata,
  input  logic                               mem_addr_ok,
  input  logic                               mem_data_ok,
  input  logic [31:0]                        mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               resp_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Owner-ID FIFO: bit is 1 when the transaction belongs to the data master
  logic [MAX_OUTSTANDING-1:0] r_owner;
  logic [PW-1:0]              r_head;
  logic [PW-1:0]              r_tail;
  logic [CW-1:0]              r_count;
  logic [SW-1:0]              r_starve;
  logic                       r_resp_err;

  logic w_full;
  logic w_empty;
  logic w_sel_data;
  logic w_push;
  logic w_pop;
  logic w_head_owner;

  assign w_full       = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty      = (r_count == '0);
  // Data normally wins; inst only takes over once data has hogged the port long enough
  assign w_sel_data   = data_req && !(inst_req && (r_starve == SW'(STARVE_LIMIT)));
  assign w_push       = mem_req && mem_addr_ok;
  assign w_pop        = mem_data_ok && !w_empty;
  assign w_head_owner = r_owner[r_head];

  assign mem_req   = (inst_req || data_req) && !w_full;
  assign mem_wr    = w_sel_data ? data_wr    : 1'b0;
  assign mem_size  = w_sel_data ? data_size  : 2'd2;
  assign mem_addr  = w_sel_data ? data_addr  : inst_addr;
  assign mem_wdata = w_sel_data ? data_wdata : 32'd0;

  assign inst_addr_ok = w_push && !w_sel_data;
  assign data_addr_ok = w_push &&  w_sel_data;
  assign inst_data_ok = w_pop  && !w_head_owner;
  assign data_data_ok = w_pop  &&  w_head_owner;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign outstanding = r_count;
  assign resp_err    = r_resp_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_owner[r_tail] <= w_sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response with nothing outstanding means the slave lost sync with us
      if (mem_data_ok && w_empty) begin
        r_resp_err <= 1'b1;
      end
      if (!inst_req || (w_push && !w_sel_data)) begin
        r_starve <= '0;
      end else if (w_push && w_sel_data && (r_starve != SW'(STARVE_LIMIT))) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a scoreboard of owner IDs filled at each address
// handshake predicts routing of in-order responses; explicit checks cover the scenario endpoints.
module tb_sram_bus_arbiter;

  localparam int MAXO = 4;
  localparam int SL   = 8;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;
  logic        resp_err;

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .outstanding(outstanding), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard: owner of each accepted transaction (0=inst, 1=data), oldest first
  bit exp_q[$];
  int m_starve = 0;
  bit m_err    = 1'b0;
  bit obs_iaok;
  bit obs_daok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict and check combinational outputs, then advance the model
  task automatic cyc(input bit ir, input bit dr, input bit aok, input bit dok, input logic [31:0] rd);
    int n;
    bit e_mreq, e_sel, e_push, e_pop, e_own;
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
    #1;
    n      = exp_q.size();
    e_mreq = (ir || dr) && (n != MAXO);
    e_sel  = dr && !(ir && (m_starve == SL));
    e_push = e_mreq && aok;
    e_pop  = dok && (n > 0);
    e_own  = (n > 0) ? exp_q[0] : 1'b0;
    chk("mem_req",      {31'd0, mem_req},      {31'd0, e_mreq});
    chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_push && !e_sel});
    chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_push && e_sel});
    chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_pop && !e_own});
    chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_pop && e_own});
    chk("outstanding",  {29'd0, outstanding},  n);
    chk("resp_err",     {31'd0, resp_err},     {31'd0, m_err});
    if (e_mreq) begin
      chk("mem_addr",  mem_addr,             e_sel ? data_addr : inst_addr);
      chk("mem_wr",    {31'd0, mem_wr},      {31'd0, e_sel && data_wr});
      chk("mem_size",  {30'd0, mem_size},    e_sel ? {30'd0, data_size} : 32'd2);
      chk("mem_wdata", mem_wdata,            e_sel ? data_wdata : 32'd0);
    end
    if (e_pop) begin
      chk("inst_rdata", inst_rdata, rd);
      chk("data_rdata", data_rdata, rd);
    end
    obs_iaok = inst_addr_ok;
    obs_daok = data_addr_ok;
    @(posedge clk);
    if (e_pop)  void'(exp_q.pop_front());
    if (e_push) exp_q.push_back(e_sel);
    if (dok && n == 0) m_err = 1'b1;
    if (!ir || (e_push && !e_sel)) m_starve = 0;
    else if (e_push && e_sel && m_starve < SL) m_starve++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_starve = 0;
    m_err    = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * MAXO && exp_q.size() > 0; k++) cyc(0, 0, 0, 1, 32'h1000_0000 + k);
    chk("drained", {29'd0, outstanding}, 0);
  endtask

  initial begin
    int dpush;
    bit seen_inst;
    inst_req = 0; data_req = 0; data_wr = 0; data_size = 2'd0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    reset = 1'b1;
    @(posedge clk);
    do_reset();
    chk("rst_outstanding", {29'd0, outstanding}, 0);
    chk("rst_resp_err",    {31'd0, resp_err},    0);
    chk("rst_mem_req",     {31'd0, mem_req},     0);

    // Single inst read
    inst_addr = 32'hBFC0_0000;
    cyc(1, 0, 1, 0, 0);
    chk("t1_out_c1", {29'd0, outstanding}, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t1_out_c2", {29'd0, outstanding}, 1);
    cyc(0, 0, 0, 1, 32'h2408_0001);
    chk("t1_out_c3", {29'd0, outstanding}, 0);

    // Conflict: data write wins first, inst follows
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF; data_wr = 1; data_size = 2'd2;
    cyc(1, 1, 1, 0, 0);
    chk("t2_data_first", {31'd0, obs_daok}, 1);
    cyc(1, 0, 1, 0, 0);
    chk("t2_inst_second", {31'd0, obs_iaok}, 1);
    cyc(0, 0, 0, 1, 32'h1111_1111);
    cyc(0, 0, 0, 1, 32'h2222_2222);

    // Starvation: inst must win after exactly SL data pushes
    data_wr = 0; data_size = 2'd1; data_addr = 32'h8000_0100; inst_addr = 32'hBFC0_0040;
    dpush = 0; seen_inst = 0;
    for (int i = 0; i < 3 * SL && !seen_inst; i++) begin
      cyc(1, 1, 1, exp_q.size() > 0, 32'h3000_0000 + i);
      if (obs_iaok) seen_inst = 1;
      else if (obs_daok) dpush++;
    end
    chk("t3_inst_seen", {31'd0, seen_inst}, 1);
    chk("t3_data_pushes", dpush, SL);
    cyc(1, 1, 1, 1, 32'h3333_0000);
    chk("t3_counter_cleared", {31'd0, obs_daok}, 1);
    drain();

    // Full: four pushes, no push-through on a same-cycle pop
    for (int i = 0; i < MAXO; i++) begin
      inst_addr = 32'hBFC0_1000 + 4 * i;
      cyc(1, 0, 1, 0, 0);
    end
    chk("t4_out_full", {29'd0, outstanding}, MAXO);
    cyc(1, 0, 1, 0, 0);
    chk("t4_blocked", {31'd0, obs_iaok}, 0);
    cyc(1, 0, 1, 1, 32'h4444_0001);
    chk("t4_no_pushthru", {31'd0, obs_iaok}, 0);
    cyc(1, 0, 1, 0, 0);
    chk("t4_resumed", {31'd0, obs_iaok}, 1);
    drain();

    // Interleaved ordering over three rounds so the head pointer wraps
    for (int r = 0; r < 3; r++) begin
      inst_addr = 32'hBFC0_2000 + 16 * r;
      data_addr = 32'h8000_2000 + 16 * r;
      cyc(1, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 1, k);
      chk("t5_round_empty", {29'd0, outstanding}, 0);
    end

    // Error on empty response is sticky; reset clears it and drops in-flight entries
    cyc(0, 0, 0, 1, 32'hBAD0_0000);
    cyc(0, 0, 0, 0, 0);
    chk("t6_err_sticky", {31'd0, resp_err}, 1);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("t6_out_two", {29'd0, outstanding}, 2);
    do_reset();
    chk("t6_rst_out", {29'd0, outstanding}, 0);
    chk("t6_rst_err", {31'd0, resp_err}, 0);
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares the single SRAM-style memory port between the fetch stage (instruction master, read-only) and the memory stage (data master, read/write).
- Pipelined req/addr_ok/data_ok protocol on all three sides; up to MAX_OUTSTANDING accepted-but-unanswered transactions in flight.
- Responses are assumed in-order from the slave and are routed back to the master that issued each transaction, using an owner-ID FIFO.
- Sits between the core and the AXI bridge / SRAM model.

Parameters:
MAX_OUTSTANDING, 4, depth of owner-ID FIFO; power of two, >=2
STARVE_LIMIT, 8, consecutive data grants while inst_req pending before inst gets forced priority; >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  instruction master request
inst_addr  in  32  instruction address
inst_addr_ok  out  1  instruction address accepted
inst_data_ok  out  1  instruction read data valid
inst_rdata  out  32  instruction read data
data_req  in  1  data master request
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  data response (read data or write ack)
data_rdata  out  32  data read data
mem_req  out  1  slave request
mem_wr  out  1  slave write
mem_size  out  2  slave size
mem_addr  out  32  slave address
mem_wdata  out  32  slave write data
mem_addr_ok  in  1  slave address accepted
mem_data_ok  in  1  slave response valid
mem_rdata  in  32  slave read data
outstanding  out  3  in-flight count, clog2(MAX_OUTSTANDING)+1 bits
resp_err  out  1  sticky: mem_data_ok seen with FIFO empty

Behaviour:
- Reset (synchronous, active-high): FIFO empty, outstanding=0, starve counter=0, resp_err=0. All outputs that are combinational from FIFO/grant state go low, because no request is forwarded when the FIFO is empty and no request is present.
- Grant (combinational, decided each cycle):
  - sel_data = data_req && !(inst_req && starve==STARVE_LIMIT).
  - Otherwise inst is selected when inst_req.
  - No grant is held across cycles; masters keep req stable until their addr_ok.
- Forwarding:
  - mem_req = (inst_req||data_req) && !full.
  - mem_addr/mem_wr/mem_size/mem_wdata are taken from the selected master.
  - For inst: wr=0, size=2, wdata=0.
- Address handshake (push = mem_req && mem_addr_ok):
  - The selected master's addr_ok = push; the other master's addr_ok = 0.
  - On push, the owner ID (0=inst, 1=data) is written at the FIFO tail on the clock edge.
- Full: when outstanding==MAX_OUTSTANDING, mem_req=0 even if a pop occurs in the same cycle. There is no same-cycle push-through.
- Response (pop = mem_data_ok && !empty):
  - The owner at the FIFO head receives data_ok in the same cycle (combinational).
  - mem_rdata is driven to both inst_rdata and data_rdata unconditionally.
- Empty with mem_data_ok: no data_ok is asserted; resp_err is set, remains 1 until reset, and the FIFO is unchanged.
- outstanding: +1 on push, -1 on pop; unchanged on a simultaneous push and pop (possible only when not full).
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each data push while inst_req=1.
  - Clears to 0 on an inst push, or in any cycle with inst_req=0.
- Zero added latency: slave addr_ok and data_ok pass through combinationally to the masters.
- Reset mid-operation: in-flight transactions are dropped, and data_ok arriving after reset sets resp_err. The integration rule is that the slave is reset together with this block.
- Pointers use log2(MAX_OUTSTANDING) bits and wrap naturally. Full and empty are derived from outstanding, not from pointer equality.

Test Plan:
- Single inst read: inst_req, inst_addr=0xBFC00000, mem_addr_ok=1 at cycle 0; mem_data_ok at cycle 2 with rdata=0x24080001 -> inst_addr_ok at cycle 0, inst_data_ok at cycle 2 with inst_rdata=0x24080001, data_data_ok=0, outstanding 0->1->1->0.
- Conflict: inst_req and data_req both high, data_wr=1, addr=0x80000010, wdata=0xDEADBEEF, mem_addr_ok always 1 -> cycle 0 forwards data (mem_wr=1, size from data), cycle 1 forwards inst; responses in order give data_data_ok then inst_data_ok.
- Starvation: data_req constantly high, inst_req high, STARVE_LIMIT=8 -> exactly 8 data pushes, then the 9th push is inst with inst_addr_ok=1, after which the counter is back to 0.
- Full: MAX_OUTSTANDING=4, 4 pushes with no mem_data_ok -> outstanding=4 and mem_req=0 despite req; one mem_data_ok -> next cycle mem_req=1 again.
- Interleaved ordering: push I,D,I,D, then 4 responses with rdata 1,2,3,4 -> inst gets 1 and 3, data gets 2 and 4; FIFO head wraps correctly over 3 rounds.
- Error/reset: mem_data_ok with empty FIFO -> resp_err=1 and stays; assert reset with 2 outstanding -> outstanding=0 and resp_err=0 on the next cycle.
